// File: rtl/run_detect_arbiter.sv
// Round-robin shared run-of-ones detector: one accepted bit per cycle updates that
// channel's saved saturating run count; results are tagged with the channel id.
module run_detect_arbiter #(
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int RUN_LEN = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req_valid,
    input  logic [N_CH-1:0] req_bit,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] req_ready,
    output logic            res_valid,
    output logic [CH_W-1:0] res_ch,
    output logic            res_det,
    output logic [N_CH-1:0] det_vec
);

    localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

    typedef logic [3:0] cnt_t;

    logic [CH_W-1:0] ptr_q, ptr_d;
    cnt_t            cnt_q [N_CH];
    cnt_t            cnt_d [N_CH];
    logic            res_valid_q, res_valid_d;
    logic [CH_W-1:0] res_ch_q, res_ch_d;
    logic            res_det_q, res_det_d;
    logic [N_CH-1:0] det_vec_q, det_vec_d;

    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_any;
    cnt_t            base;

    // Two passes: channels at or above the pointer first, then the wrapped ones below it.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (!gnt_any && req_valid[k] && (CH_W'(k) >= ptr_q)) begin
                grant[k] = 1'b1;
                gnt_idx  = CH_W'(k);
                gnt_any  = 1'b1;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (!gnt_any && req_valid[k] && (CH_W'(k) < ptr_q)) begin
                grant[k] = 1'b1;
                gnt_idx  = CH_W'(k);
                gnt_any  = 1'b1;
            end
        end
        if (reset) begin
            grant   = '0;
            gnt_any = 1'b0;
        end
    end

    assign req_ready = grant;

    always_comb begin
        ptr_d       = ptr_q;
        base        = '0;
        res_valid_d = gnt_any;
        res_ch_d    = res_ch_q;
        res_det_d   = res_det_q;
        if (gnt_any) begin
            ptr_d    = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            res_ch_d = gnt_idx;
        end
        // Clear is applied before the accepted bit on the same channel.
        for (int k = 0; k < N_CH; k++) begin
            base = clr[k] ? 4'd0 : cnt_q[k];
            if (grant[k]) begin
                if (req_bit[k]) begin
                    cnt_d[k] = (base == RUN_MAX) ? RUN_MAX : base + 4'd1;
                end else begin
                    cnt_d[k] = 4'd0;
                end
            end else begin
                cnt_d[k] = base;
            end
            det_vec_d[k] = (cnt_d[k] == RUN_MAX);
        end
        if (gnt_any) begin
            res_det_d = |(grant & det_vec_d);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: the count array is tiny and its value is architectural, so it is reset too.
        if (reset) begin
            ptr_q       <= '0;
            cnt_q       <= '{default: '0};
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_det_q   <= 1'b0;
            det_vec_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_det_q   <= res_det_d;
            det_vec_q   <= det_vec_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_det   = res_det_q;
    assign det_vec   = det_vec_q;

endmodule

// File: tb/tb_run_detect_arbiter.sv
// Bench for run_detect_arbiter: three instances (RUN_LEN 1, 2, 3) share stimulus and are
// compared every cycle against a queue-free arithmetic model, plus hand-derived vectors.
module tb_run_detect_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid, req_bit, clr;

    logic [3:0] rdy [3];
    logic       rv  [3];
    logic [1:0] ch  [3];
    logic       det [3];
    logic [3:0] dv  [3];

    int checks = 0;
    int errors = 0;

    int         run_len [3] = '{1, 2, 3};
    int         mcnt [3][4];
    int         mptr;
    logic       m_rv;
    int         m_ch;
    logic       m_det [3];
    logic [3:0] rdy_seen;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [3:0] rdy;
        logic       rv;
        logic [1:0] ch;
        logic       det;
        logic [3:0] dv;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    run_detect_arbiter #(.N_CH(4), .CH_W(2), .RUN_LEN(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit), .clr(clr),
        .req_ready(rdy[0]), .res_valid(rv[0]), .res_ch(ch[0]), .res_det(det[0]), .det_vec(dv[0])
    );
    run_detect_arbiter #(.N_CH(4), .CH_W(2), .RUN_LEN(2)) u_l2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit), .clr(clr),
        .req_ready(rdy[1]), .res_valid(rv[1]), .res_ch(ch[1]), .res_det(det[1]), .det_vec(dv[1])
    );
    run_detect_arbiter #(.N_CH(4), .CH_W(2), .RUN_LEN(3)) u_l3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit), .clr(clr),
        .req_ready(rdy[2]), .res_valid(rv[2]), .res_ch(ch[2]), .res_det(det[2]), .det_vec(dv[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [3:0] x, input int k);
        return x[k[1:0]];
    endfunction

    function automatic int model_grant(input logic r, input logic [3:0] v);
        if (r) return -1;
        for (int i = 0; i < 4; i++) begin
            if (bit_of(v, (mptr + i) % 4)) return (mptr + i) % 4;
        end
        return -1;
    endfunction

    // Applies one cycle of stimulus, checks the combinational grant, then the registered results.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        int         g;
        logic [3:0] exp_rdy;
        logic [3:0] exp_dv;
        reset     = r;
        req_valid = v;
        req_bit   = b;
        clr       = c;
        #3;
        g        = model_grant(r, v);
        exp_rdy  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        rdy_seen = rdy[1];
        for (int i = 0; i < 3; i++)
            check($sformatf("req_ready L%0d", run_len[i]), 32'(rdy[i]), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 4; k++) mcnt[i][k] = 0;
                m_det[i] = 1'b0;
            end
            mptr = 0;
            m_rv = 1'b0;
            m_ch = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (bit_of(c, k)) mcnt[i][k] = 0;
                    if (k == g) begin
                        if (bit_of(b, k)) mcnt[i][k] = (mcnt[i][k] + 1 > run_len[i]) ? run_len[i] : mcnt[i][k] + 1;
                        else mcnt[i][k] = 0;
                    end
                end
                if (g >= 0) m_det[i] = (mcnt[i][g] == run_len[i]);
            end
            m_rv = (g >= 0);
            if (g >= 0) begin
                m_ch = g;
                mptr = (g + 1) % 4;
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_dv = '0;
            for (int k = 0; k < 4; k++) exp_dv[k[1:0]] = (mcnt[i][k] == run_len[i]);
            check($sformatf("res_valid L%0d", run_len[i]), 32'(rv[i]), 32'(m_rv));
            check($sformatf("res_ch L%0d", run_len[i]), 32'(ch[i]), m_ch);
            check($sformatf("res_det L%0d", run_len[i]), 32'(det[i]), 32'(m_det[i]));
            check($sformatf("det_vec L%0d", run_len[i]), 32'(dv[i]), 32'(exp_dv));
        end
    endtask

    initial begin
        // Hand-derived expectations for the RUN_LEN=2 instance: {rst, vld, bits, clr, rdy, rv, ch, det, dv}.
        tbl[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0, 4'h0};
        tbl[2]  = '{1'b0, 4'h2, 4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 4'h2, 4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 1'b1, 4'h2};
        tbl[4]  = '{1'b0, 4'h2, 4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 1'b1, 4'h2};
        tbl[5]  = '{1'b0, 4'h2, 4'h0, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0};
        tbl[6]  = '{1'b0, 4'h2, 4'h2, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0};
        tbl[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1, 1'b0, 4'h0};
        tbl[8]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 4'h0};
        tbl[9]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0, 4'h0};
        tbl[10] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0};
        tbl[11] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0, 4'h0};
        tbl[12] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0, 4'h0};
        tbl[13] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h1, 1'b1, 2'd0, 1'b1, 4'h1};
        tbl[14] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h2, 1'b1, 2'd1, 1'b1, 4'h3};
        tbl[15] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h4, 1'b1, 2'd2, 1'b1, 4'h7};
        tbl[16] = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h8, 1'b1, 2'd3, 1'b1, 4'hF};
        tbl[17] = '{1'b0, 4'h0, 4'h0, 4'h5, 4'h0, 1'b0, 2'd3, 1'b1, 4'hA};

        reset     = 1'b1;
        req_valid = '0;
        req_bit   = '0;
        clr       = '0;
        mptr      = 0;
        m_rv      = 1'b0;
        m_ch      = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) mcnt[i][k] = 0;
            m_det[i] = 1'b0;
        end
        @(posedge clk);
        #1;

        for (int n = 0; n < NV; n++) begin
            cycle(tbl[n].rst, tbl[n].vld, tbl[n].bits, tbl[n].clr);
            check($sformatf("tbl%0d ready", n), 32'(rdy_seen), 32'(tbl[n].rdy));
            check($sformatf("tbl%0d res_valid", n), 32'(rv[1]), 32'(tbl[n].rv));
            check($sformatf("tbl%0d res_ch", n), 32'(ch[1]), 32'(tbl[n].ch));
            check($sformatf("tbl%0d res_det", n), 32'(det[1]), 32'(tbl[n].det));
            check($sformatf("tbl%0d det_vec", n), 32'(dv[1]), 32'(tbl[n].dv));
        end

        // Skip and wrap: grant 2, then only 1 and 3 valid -> 3, 1, 3.
        cycle(1'b0, 4'h4, 4'h0, 4'h0);
        check("wrap ready 2", 32'(rdy_seen), 32'(4'h4));
        cycle(1'b0, 4'hA, 4'h0, 4'h0);
        check("wrap ready 3a", 32'(rdy_seen), 32'(4'h8));
        check("wrap ch 3a", 32'(ch[1]), 32'(2'd3));
        cycle(1'b0, 4'hA, 4'h0, 4'h0);
        check("wrap ready 1", 32'(rdy_seen), 32'(4'h2));
        check("wrap ch 1", 32'(ch[1]), 32'(2'd1));
        cycle(1'b0, 4'hA, 4'h0, 4'h0);
        check("wrap ready 3b", 32'(rdy_seen), 32'(4'h8));
        check("wrap ch 3b", 32'(ch[1]), 32'(2'd3));

        // Clear colliding with an accepted bit on channel 0.
        cycle(1'b0, 4'h1, 4'h1, 4'h0);
        cycle(1'b0, 4'h1, 4'h1, 4'h0);
        check("clr pre det", 32'(det[1]), 32'(1'b1));
        cycle(1'b0, 4'h1, 4'h1, 4'h1);
        check("clr+1 det L2", 32'(det[1]), 32'(1'b0));
        check("clr+1 dv0 L2", 32'(dv[1][0]), 32'(1'b0));
        check("clr+1 det L1", 32'(det[0]), 32'(1'b1));
        cycle(1'b0, 4'h1, 4'h1, 4'h0);
        check("clr+1 then 1", 32'(det[1]), 32'(1'b1));
        cycle(1'b0, 4'h1, 4'h0, 4'h1);
        check("clr+0 det L2", 32'(det[1]), 32'(1'b0));
        cycle(1'b0, 4'h1, 4'h1, 4'h0);
        check("clr+0 then 1", 32'(det[1]), 32'(1'b0));

        // Mid-run reset on the RUN_LEN=3 instance.
        cycle(1'b0, 4'h4, 4'h4, 4'h0);
        check("mid pre 1", 32'(det[2]), 32'(1'b0));
        cycle(1'b0, 4'h4, 4'h4, 4'h0);
        check("mid pre 2", 32'(det[2]), 32'(1'b0));
        cycle(1'b1, 4'h4, 4'h4, 4'h0);
        check("mid rst ready", 32'(rdy_seen), 32'(4'h0));
        check("mid rst dv", 32'(dv[2]), 32'(4'h0));
        check("mid rst rv", 32'(rv[2]), 32'(1'b0));
        cycle(1'b0, 4'h4, 4'h4, 4'h0);
        check("mid post 1", 32'(det[2]), 32'(1'b0));
        cycle(1'b0, 4'h4, 4'h4, 4'h0);
        check("mid post 2", 32'(det[2]), 32'(1'b0));
        cycle(1'b0, 4'h4, 4'h4, 4'h0);
        check("mid post 3", 32'(det[2]), 32'(1'b1));
        check("mid post dv", 32'(dv[2]), 32'(4'h4));

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 39) == 0), 4'($urandom), 4'($urandom),
                  4'($urandom & $urandom & $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_detect_arbiter.md
# run_detect_arbiter

Shares one run-of-ones detector between `N_CH` serial bit streams. Each channel presents one bit at a time through a valid/ready handshake. A round-robin arbiter accepts at most one bit per cycle and applies it to that channel's saved Moore detector state. The block reports a per-cycle result tagged with the channel id and keeps a per-channel detect vector for downstream consumers.

## Interface
- `N_CH`, default 4: number of requesting channels, legal range 2..8.
- `CH_W`, default 2: channel id width, equal to ceil(log2(N_CH)).
- `RUN_LEN`, default 2: consecutive ones needed to assert detect, legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input N_CH: channel k has a bit pending.
- `req_bit` input N_CH: the pending bit for channel k; sampled only when accepted.
- `clr` input N_CH: per-channel synchronous clear of the run state.
- `req_ready` output N_CH: one-hot grant, combinational; a transfer occurs when `req_valid[k] & req_ready[k]`.
- `res_valid` output 1: registered; one accepted bit was processed last cycle.
- `res_ch` output CH_W: registered; channel of that bit.
- `res_det` output 1: registered; detect state of `res_ch` after the update.
- `det_vec` output N_CH: registered Moore output, bit k = (run count of channel k == RUN_LEN).

## Operation
- Per-channel state: a 4-bit saturating run count `cnt[k]`, range 0..RUN_LEN.
  - Equivalent Moore states: ZERO (0), PARTIAL (1..RUN_LEN-1), DETECT (RUN_LEN).
- Update on accept for channel k:
  - bit=1: `cnt[k] = min(cnt[k]+1, RUN_LEN)`.
  - bit=0: `cnt[k] = 0`.
- Detection is non-overlapping and level-style: once in DETECT, the channel stays there on further ones and leaves only on a zero, `clr`, or `reset`.
- Arbitration: rotating pointer `ptr`, reset to 0.
  - Grant the first k with `req_valid[k]` = 1, searching ptr, ptr+1, … and wrapping modulo N_CH.
  - After a grant to channel g, `ptr = (g+1) mod N_CH`.
  - If nothing is granted, `ptr` holds.
- `req_ready` is all-zero when `req_valid` is all-zero or `reset` = 1.
- `req_ready` depends only on `req_valid`, `ptr` and `reset`. It must not depend on `req_bit` or `clr`.
- `clr[k]`:
  - Sets `cnt[k]` to 0 at the next edge.
  - It does not consume a request, does not affect arbitration, and does not generate `res_valid`.
- Simultaneous `clr[k]` and accept on k: clear first, then apply the bit, so `cnt[k]` becomes (bit ? 1 : 0) and `res_det` is computed from that value. When RUN_LEN=1 and bit=1, the result is DETECT.
- `clr` on channels other than the accepted one applies independently in the same cycle.
- Channels that are not accepted and not cleared hold their state, regardless of `req_bit`.

## Timing
- Reset (`reset` high at an edge) gives:
  - `cnt` all 0, `ptr` = 0.
  - `res_valid` = 0, `res_ch` = 0, `res_det` = 0, `det_vec` = 0.
- Reset has priority over accepts and `clr` in the same cycle, and the accept is lost. A mid-run reset discards all run progress.
- Latency: a bit accepted in cycle t appears on `res_valid`, `res_ch`, `res_det` and the updated `det_vec` in cycle t+1. `res_valid` is high for exactly one cycle per accept.
- Throughput: one accepted bit per cycle in aggregate.
- With all N_CH channels continuously valid, each channel is granted exactly once every N_CH cycles.
- Requesters may hold `req_valid` indefinitely. A bit is consumed only on the cycle its ready is high.
- `det_vec` changes only at the edge following an accept, `clr`, or `reset` on that channel.
- With `res_valid` = 0, `res_ch` and `res_det` hold their previous values.

## Test plan
- Reset values: assert `reset` with all `req_valid` = 1. Required: `req_ready` = 0; the cycle after release shows `res_valid` = 0, `det_vec` = 0, and the first grant goes to channel 0.
- Single channel, RUN_LEN=2: drive only channel 1 with bits 1,1,1,0,1. Required: `res_det` = 0,1,1,0,0 on consecutive cycles, `res_ch` = 1 each time, and `det_vec[1]` follows the same sequence.
- Round-robin fairness: hold all four `req_valid` high for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3 and one `res_valid` per cycle.
- Skip and wrap: first grant channel 2, then leave only channels 1 and 3 valid. Required: grant 3, then 1, then 3; `ptr` wraps correctly.
- Clear collision: bring channel 0 to DETECT, then assert `clr[0]` together with an accepted bit 1. Required: `res_det` = 0 and `cnt` = 1 for RUN_LEN=2; a repeat with bit 0 gives `cnt` = 0.
- Mid-run reset, RUN_LEN=3: send channel 2 the bits 1,1, then pulse `reset`, then send 1,1,1. Required: `res_det` = 0,0 before the reset, 0,0,1 after it, and `det_vec` = 0 immediately after the reset.
